// File: rtl/vga_key_renderer.sv
// vga_key_renderer
//   Single-clock VGA timing generator with a piano-key renderer. The active
//   area shows a sky band of SKY_ROWS rows above NUM_KEYS keys, each KEY_W
//   pixels wide. The leftmost column of every key is a black separator, and
//   any columns left over past the last key are black. Pressed keys are drawn
//   green. Key state is sampled once per frame, at the last pixel of the
//   frame, so a frame never shows a partly updated keyboard.
//
//   Optional build macro VGA_KEY_HOLD_EN: each key keeps its highlight for
//   HOLD_FRAMES extra frames after release. Without the macro no hold logic
//   is built.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   keys_in      in   [NUM_KEYS] key pressed = 1, asynchronous to clk
//   clk_out      out  pixel clock to the DAC (CLK_DIV clk periods, 50% duty)
//   hsync_out    out  horizontal sync, active low
//   vsync_out    out  vertical sync, active low
//   sync_b_out   out  composite sync (hsync AND vsync), active low
//   blank_b_out  out  1 inside the active area
//   red/green/blue out [8] pixel colour
//
// Every video output comes from a register that updates only on pixel-enable
// cycles. Colour and syncs lag the raster counters by two pixels.

module vga_key_renderer #(
  parameter int NUM_KEYS    = 12,
  parameter int CLK_DIV     = 2,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SKY_ROWS    = 192,
  parameter int HOLD_FRAMES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys_in,
  output logic                clk_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                sync_b_out,
  output logic                blank_b_out,
  output logic [7:0]          red,
  output logic [7:0]          green,
  output logic [7:0]          blue
);

  localparam int KEY_W   = H_ACTIVE / NUM_KEYS;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(CLK_DIV);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int CW      = (KEY_W > 1) ? $clog2(KEY_W) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] SKY_LIM  = VW'(SKY_ROWS);
  localparam logic [HW-1:0] KEY_LIM  = HW'(NUM_KEYS);
  localparam logic [CW-1:0] COL_LAST = CW'(KEY_W - 1);

  // Colour class carried from the decode stage to the colour stage.
  typedef enum logic [1:0] {
    CLS_BLACK = 2'd0,
    CLS_SKY   = 2'd1,
    CLS_WHITE = 2'd2,
    CLS_LIT   = 2'd3
  } cls_e;

  logic [DW-1:0]       div_q, div_d;
  logic                clk_out_q, clk_out_d;
  logic [HW-1:0]       hcnt_q, hcnt_d;
  logic [VW-1:0]       vcnt_q, vcnt_d;
  logic [CW-1:0]       col_q, col_d;
  logic [HW-1:0]       key_idx_q, key_idx_d;
  logic [NUM_KEYS-1:0] key_meta_q, key_meta_d;
  logic [NUM_KEYS-1:0] key_s_q, key_s_d;
  logic [NUM_KEYS-1:0] key_frame_q, key_frame_d;
  logic                s1_hs_q, s1_hs_d;
  logic                s1_vs_q, s1_vs_d;
  logic                s1_act_q, s1_act_d;
  cls_e                s1_cls_q, s1_cls_d;
  logic                hsync_q, hsync_d;
  logic                vsync_q, vsync_d;
  logic                sync_b_q, sync_b_d;
  logic                blank_b_q, blank_b_d;
  logic [23:0]         rgb_q, rgb_d;

  logic                pix_en;
  logic                frame_end;
  logic [NUM_KEYS-1:0] hold_nz;
  logic [NUM_KEYS-1:0] lit_vec;
  logic                key_lit;
  logic                active;
  cls_e                cls_c;
  logic [23:0]         rgb_c;

  // Pixel divider, raster counters and per-key column tracking.
  always_comb begin
    pix_en    = (div_q == DIV_LAST);
    frame_end = pix_en && (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
    if (pix_en) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end
    clk_out_d = (div_d >= DIV_HALF);

    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    col_d     = col_q;
    key_idx_d = key_idx_q;
    if (pix_en) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d    = '0;
        col_d     = '0;
        key_idx_d = '0;
        if (vcnt_q == V_LAST) begin
          vcnt_d = '0;
        end else begin
          vcnt_d = vcnt_q + 1'b1;
        end
      end else begin
        hcnt_d = hcnt_q + 1'b1;
        // col/key_idx are hcnt split into (hcnt % KEY_W, hcnt / KEY_W)
        // without a divider.
        if (col_q == COL_LAST) begin
          col_d     = '0;
          key_idx_d = key_idx_q + 1'b1;
        end else begin
          col_d     = col_q + 1'b1;
          key_idx_d = key_idx_q;
        end
      end
    end else begin
      hcnt_d = hcnt_q;
    end
  end

  // Key synchroniser and once-per-frame snapshot.
  always_comb begin
    key_meta_d = keys_in;
    key_s_d    = key_meta_q;
    if (frame_end) begin
      key_frame_d = key_s_q;
    end else begin
      key_frame_d = key_frame_q;
    end
  end

`ifdef VGA_KEY_HOLD_EN
  localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES);

  logic [NUM_KEYS-1:0][HOLD_W-1:0] hold_q, hold_d;

  // Hold counters, stepped at frame end. Reloading while the outgoing
  // snapshot is still set starts the countdown in the first frame after the
  // key drops out, so a one-frame tap stays lit for 1+HOLD_FRAMES frames.
  always_comb begin
    hold_d  = hold_q;
    hold_nz = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      hold_nz[i] = (hold_q[i] != '0);
      if (frame_end) begin
        if (key_s_q[i] || key_frame_q[i]) begin
          hold_d[i] = HOLD_INIT;
        end else if (hold_q[i] != '0) begin
          hold_d[i] = hold_q[i] - 1'b1;
        end else begin
          hold_d[i] = hold_q[i];
        end
      end else begin
        hold_d[i] = hold_q[i];
      end
    end
  end

  // Hold counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  // Without hold support the highlight follows the frame snapshot only.
  always_comb begin
    hold_nz = '0;
  end
`endif

  // Stage 1: classify the pixel addressed by the current counters.
  always_comb begin
    lit_vec = key_frame_q | hold_nz;
    key_lit = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      key_lit = key_lit | (lit_vec[i] & (key_idx_q == HW'(i)));
    end
    active = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);

    if (!active) begin
      cls_c = CLS_BLACK;
    end else if (vcnt_q < SKY_LIM) begin
      cls_c = CLS_SKY;
    end else if (key_idx_q >= KEY_LIM) begin
      cls_c = CLS_BLACK;
    end else if (col_q == '0) begin
      cls_c = CLS_BLACK;
    end else if (key_lit) begin
      cls_c = CLS_LIT;
    end else begin
      cls_c = CLS_WHITE;
    end

    if (pix_en) begin
      s1_hs_d  = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
      s1_vs_d  = (vcnt_q >= VS_START) && (vcnt_q < VS_END);
      s1_act_d = active;
      s1_cls_d = cls_c;
    end else begin
      s1_hs_d  = s1_hs_q;
      s1_vs_d  = s1_vs_q;
      s1_act_d = s1_act_q;
      s1_cls_d = s1_cls_q;
    end
  end

  // Stage 2: colour lookup and active-low sync outputs.
  always_comb begin
    case (s1_cls_q)
      CLS_BLACK: rgb_c = 24'h000000;
      CLS_SKY:   rgb_c = 24'hDAE8FC;
      CLS_WHITE: rgb_c = 24'hFFFFFF;
      CLS_LIT:   rgb_c = 24'h00FF00;
      default:   rgb_c = 24'h000000;
    endcase
    if (pix_en) begin
      hsync_d   = ~s1_hs_q;
      vsync_d   = ~s1_vs_q;
      sync_b_d  = ~(s1_hs_q | s1_vs_q);
      blank_b_d = s1_act_q;
      rgb_d     = rgb_c;
    end else begin
      hsync_d   = hsync_q;
      vsync_d   = vsync_q;
      sync_b_d  = sync_b_q;
      blank_b_d = blank_b_q;
      rgb_d     = rgb_q;
    end
  end

  // State registers. Stage-1 sync flags are active-high so their reset
  // value of 0 keeps the outputs inactive while the pipeline refills.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q       <= '0;
      clk_out_q   <= 1'b0;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      col_q       <= '0;
      key_idx_q   <= '0;
      key_meta_q  <= '0;
      key_s_q     <= '0;
      key_frame_q <= '0;
      s1_hs_q     <= 1'b0;
      s1_vs_q     <= 1'b0;
      s1_act_q    <= 1'b0;
      s1_cls_q    <= CLS_BLACK;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      sync_b_q    <= 1'b1;
      blank_b_q   <= 1'b0;
      rgb_q       <= 24'h000000;
    end else begin
      div_q       <= div_d;
      clk_out_q   <= clk_out_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      col_q       <= col_d;
      key_idx_q   <= key_idx_d;
      key_meta_q  <= key_meta_d;
      key_s_q     <= key_s_d;
      key_frame_q <= key_frame_d;
      s1_hs_q     <= s1_hs_d;
      s1_vs_q     <= s1_vs_d;
      s1_act_q    <= s1_act_d;
      s1_cls_q    <= s1_cls_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      sync_b_q    <= sync_b_d;
      blank_b_q   <= blank_b_d;
      rgb_q       <= rgb_d;
    end
  end

  assign clk_out     = clk_out_q;
  assign hsync_out   = hsync_q;
  assign vsync_out   = vsync_q;
  assign sync_b_out  = sync_b_q;
  assign blank_b_out = blank_b_q;
  assign red         = rgb_q[23:16];
  assign green       = rgb_q[15:8];
  assign blue        = rgb_q[7:0];

endmodule

// File: tb/tb_vga_key_renderer.sv
// Testbench for vga_key_renderer on a reduced raster (56x23 totals) so that
// several whole frames fit in a short run. NUM_KEYS=7 gives KEY_W=5 with
// black remainder columns 35..39; CLK_DIV=4 exercises a wider divider.
// Every pixel is compared with a reference computed from the raster rules:
// pixel position is derived from the number of pixel clocks since reset, and
// each frame shows the keys_in value held at the start of that frame.
module tb_vga_key_renderer;

  localparam int NK   = 7;
  localparam int CD   = 4;
  localparam int HA   = 40;
  localparam int HFP  = 4;
  localparam int HSY  = 6;
  localparam int HBP  = 6;
  localparam int VA   = 16;
  localparam int VFP  = 2;
  localparam int VSY  = 2;
  localparam int VBP  = 3;
  localparam int SKY  = 4;
  localparam int HF   = 2;
  localparam int HT   = HA + HFP + HSY + HBP;
  localparam int VT   = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;
  localparam int KW   = HA / NK;
`ifdef VGA_KEY_HOLD_EN
  localparam int HOLD_EFF = HF;
`else
  localparam int HOLD_EFF = 0;
`endif

  logic          clk;
  logic          reset;
  logic [NK-1:0] keys_in;
  logic          clk_out, hsync_out, vsync_out, sync_b_out, blank_b_out;
  logic [7:0]    red, green, blue;

  int total = 0;
  int bad   = 0;
  int k     = 0;
  logic [NK-1:0] fk [0:15];

  vga_key_renderer #(
    .NUM_KEYS(NK), .CLK_DIV(CD),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .SKY_ROWS(SKY), .HOLD_FRAMES(HF)
  ) dut (
    .clk(clk), .reset(reset), .keys_in(keys_in),
    .clk_out(clk_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .sync_b_out(sync_b_out), .blank_b_out(blank_b_out),
    .red(red), .green(green), .blue(blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  // Key idx is shown lit in frame f if it was held at the start of frame f
  // or of any of the HOLD_EFF frames before it.
  function automatic logic ref_lit(input int idx, input int f);
    for (int j = 0; j <= HOLD_EFF; j++) begin
      if (f - j >= 0) begin
        if (fk[f - j][idx]) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // {hsync, vsync, sync_b, blank_b, rgb} for pixel number q since reset.
  function automatic logic [27:0] ref_pixel(input int q);
    int x, y, f;
    logic hs, vs, act;
    logic [23:0] rgb;
    x   = q % HT;
    y   = (q / HT) % VT;
    f   = q / FRAME;
    act = (x < HA) && (y < VA);
    hs  = !((x >= HA + HFP) && (x < HA + HFP + HSY));
    vs  = !((y >= VA + VFP) && (y < VA + VFP + VSY));
    if (!act)                 rgb = 24'h000000;
    else if (y < SKY)         rgb = 24'hDAE8FC;
    else if (x / KW >= NK)    rgb = 24'h000000;
    else if (x % KW == 0)     rgb = 24'h000000;
    else if (ref_lit(x / KW, f)) rgb = 24'h00FF00;
    else                      rgb = 24'hFFFFFF;
    return {hs, vs, hs & vs, act, rgb};
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, ".clk_out"}, {23'd0, clk_out}, 24'd0);
    check({tag, ".hsync"},   {23'd0, hsync_out}, 24'd1);
    check({tag, ".vsync"},   {23'd0, vsync_out}, 24'd1);
    check({tag, ".sync_b"},  {23'd0, sync_b_out}, 24'd1);
    check({tag, ".blank_b"}, {23'd0, blank_b_out}, 24'd0);
    check({tag, ".rgb"},     {red, green, blue}, 24'h000000);
  endtask

  task automatic clear_model();
    k = 0;
    for (int i = 0; i < 16; i++) fk[i] = '0;
  endtask

  // Run ncyc clocks after reset release, checking every output each cycle.
  task automatic run(input int ncyc);
    int n;
    logic [27:0] e;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      k++;
      check("clk_out", {23'd0, clk_out}, ((k % CD) >= CD / 2) ? 24'd1 : 24'd0);
      if (k % CD == 0) begin
        n = k / CD;
        if ((n % FRAME == 0) && (n / FRAME < 16)) fk[n / FRAME] = keys_in;
        if (n < 2) e = {1'b1, 1'b1, 1'b1, 1'b0, 24'h000000};
        else       e = ref_pixel(n - 2);
        check("hsync",   {23'd0, hsync_out},   {23'd0, e[27]});
        check("vsync",   {23'd0, vsync_out},   {23'd0, e[26]});
        check("sync_b",  {23'd0, sync_b_out},  {23'd0, e[25]});
        check("blank_b", {23'd0, blank_b_out}, {23'd0, e[24]});
        check("rgb",     {red, green, blue},   e[23:0]);
        // New key pattern mid-frame; it must not show until the next frame.
        if (n % FRAME == FRAME / 2) keys_in = NK'($urandom);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    keys_in = '0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");

    // Key 3 held from the start; first frame still shows it unlit.
    keys_in = 7'b0001000;
    @(negedge clk);
    reset = 1'b0;
    run(FRAME * CD * 3 + 1234 * CD + 2);

    // Mid-frame reset: outputs drop to reset values at once.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    repeat (5) @(posedge clk);
    #1;
    check_reset_vals("rst_held");
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    run(FRAME * CD * 3 + 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
